// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze solver: directions, FSM states, cell
// coordinates and the neighbour arithmetic used by the depth-first search.
package maze_pkg;

  localparam int COORD_W  = 4;
  localparam int MAZE_DIM = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } cell_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    LEFT  = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_START,
    MARK,
    PROBE,
    BACK,
    DONE,
    REPLAY,
    FAIL
  } state_t;

  // The encoding makes the reverse move simply 3 - d.
  function automatic dir_t opposite(dir_t d);
    return dir_t'(2'd3 - d);
  endfunction

  function automatic logic in_bounds(cell_t c, dir_t d);
    case (d)
      UP:      return c.x != '0;
      RIGHT:   return c.y != coord_t'(MAZE_DIM - 1);
      LEFT:    return c.y != '0;
      default: return c.x != coord_t'(MAZE_DIM - 1);
    endcase
  endfunction

  // An out-of-bounds step returns the cell unchanged rather than wrapping.
  function automatic cell_t neighbour(cell_t c, dir_t d);
    cell_t n;
    n = c;
    if (in_bounds(c, d)) begin
      case (d)
        UP:      n.x = c.x - coord_t'(1);
        RIGHT:   n.y = c.y + coord_t'(1);
        LEFT:    n.y = c.y - coord_t'(1);
        default: n.x = c.x + coord_t'(1);
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/maze_solver_if.sv
// Port bundle between the solver and the 16x16 maze bit-memory.
// The memory answers reads combinationally and captures writes on the next clk edge.
interface maze_solver_if;
  import maze_pkg::*;

  logic   mem_rd;
  logic   mem_wr;
  logic   mem_din;
  coord_t x;
  coord_t y;
  logic   mem_dout;

  modport master (output mem_rd, output mem_wr, output mem_din, output x, output y,
                  input  mem_dout);
  modport slave  (input  mem_rd, input  mem_wr, input  mem_din, input  x, input  y,
                  output mem_dout);
endinterface

// File: rtl/maze_solver_dir_stack.sv
// LIFO of search directions; the top feeds backtracking and an indexed port
// feeds path replay from the bottom of the stack.
module dir_stack
  import maze_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  dir_t          wdata,
  output dir_t          rdata_top,
  input  logic [AW-1:0] rd_idx,
  output dir_t          rdata_idx,
  output logic [AW:0]   sp
);

  typedef logic [AW-1:0] idx_t;
  typedef logic [AW:0]   ptr_t;

  dir_t mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sp <= '0;
    else if (clear) sp <= '0;
    else if (push)  sp <= sp + ptr_t'(1);
    else if (pop)   sp <= sp - ptr_t'(1);
  end

  // NOTE: the storage array has no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[sp[AW-1:0]] <= wdata;
  end

  assign rdata_top = mem[sp[AW-1:0] - idx_t'(1)];
  assign rdata_idx = mem[rd_idx];

  // One push per newly visited cell, so the stack can never fill up.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
                                !(push && sp == ptr_t'(DEPTH)));

endmodule

// File: rtl/maze_solver.sv
// Depth-first maze solver: marks visited cells in the maze memory, keeps the
// path as a stack of moves and replays it on request.
module maze_solver
  import maze_pkg::*;
#(
  parameter int START_X     = 0,
  parameter int START_Y     = 0,
  parameter int GOAL_X      = 15,
  parameter int GOAL_Y      = 15,
  parameter int STACK_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 run,
  maze_solver_if.master        mem,
  output logic                 done,
  output logic                 fail,
  output logic [1:0]           move,
  output logic                 move_valid,
  output logic [8:0]           path_len
);

  localparam int AW = $clog2(STACK_DEPTH);
  typedef logic [AW-1:0] idx_t;
  typedef logic [AW:0]   ptr_t;

  localparam cell_t START_CELL = '{x: coord_t'(START_X), y: coord_t'(START_Y)};
  localparam cell_t GOAL_CELL  = '{x: coord_t'(GOAL_X),  y: coord_t'(GOAL_Y)};

  state_t     state, state_nxt;
  cell_t      cur, cur_nxt;
  dir_t       dir, dir_nxt;
  logic [8:0] path_len_nxt;
  idx_t       idx, idx_nxt;

  logic  push, pop, clear, restart;
  dir_t  top_d, idx_d;
  ptr_t  sp;
  cell_t nb;
  logic  nb_ok;

  dir_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .wdata     (dir),
    .rdata_top (top_d),
    .rd_idx    (idx),
    .rdata_idx (idx_d),
    .sp        (sp)
  );

  assign nb_ok       = in_bounds(cur, dir);
  assign nb          = neighbour(cur, dir);
  assign mem.mem_din = 1'b1;
  assign done        = (state == DONE) || (state == REPLAY);
  assign fail        = (state == FAIL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= START_CELL;
      dir      <= UP;
      path_len <= '0;
      idx      <= '0;
    end else begin
      state    <= state_nxt;
      cur      <= cur_nxt;
      dir      <= dir_nxt;
      path_len <= path_len_nxt;
      idx      <= idx_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt    = state;
    cur_nxt      = cur;
    dir_nxt      = dir;
    path_len_nxt = path_len;
    idx_nxt      = idx;
    push         = 1'b0;
    pop          = 1'b0;
    clear        = 1'b0;
    restart      = 1'b0;
    mem.mem_rd   = 1'b0;
    mem.mem_wr   = 1'b0;
    mem.x        = cur.x;
    mem.y        = cur.y;
    move         = 2'b00;
    move_valid   = 1'b0;

    case (state)
      IDLE, FAIL: restart = start;
      RD_START: begin
        mem.mem_rd = 1'b1;
        state_nxt  = mem.mem_dout ? FAIL : MARK;
      end
      MARK: begin
        mem.mem_wr = 1'b1;
        if (cur == GOAL_CELL) begin
          path_len_nxt = 9'(sp);
          state_nxt    = DONE;
        end else begin
          dir_nxt   = UP;
          state_nxt = PROBE;
        end
      end
      PROBE: begin
        mem.x      = nb.x;
        mem.y      = nb.y;
        mem.mem_rd = nb_ok;
        if (nb_ok && !mem.mem_dout) begin
          push      = 1'b1;
          cur_nxt   = nb;
          state_nxt = MARK;
        end else if (dir != DOWN) begin
          dir_nxt = dir_t'(dir + 2'd1);
        end else begin
          state_nxt = BACK;
        end
      end
      BACK: begin
        if (sp == '0) begin
          state_nxt = FAIL;
        end else begin
          pop     = 1'b1;
          cur_nxt = neighbour(cur, opposite(top_d));
          // A popped DOWN has no remaining directions, so keep unwinding.
          if (top_d != DOWN) begin
            dir_nxt   = dir_t'(top_d + 2'd1);
            state_nxt = PROBE;
          end
        end
      end
      DONE: begin
        if (start) begin
          restart = 1'b1;
        end else if (run && path_len != '0) begin
          idx_nxt   = '0;
          state_nxt = REPLAY;
        end
      end
      REPLAY: begin
        move_valid = 1'b1;
        move       = idx_d;
        idx_nxt    = idx + idx_t'(1);
        if (ptr_t'(idx) == sp - ptr_t'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase

    if (restart) begin
      clear        = 1'b1;
      cur_nxt      = START_CELL;
      dir_nxt      = UP;
      path_len_nxt = '0;
      state_nxt    = RD_START;
    end
  end

endmodule

// File: tb/tb_maze_solver.sv
// Self-checking bench for maze_solver: a behavioural maze memory, a scoreboard
// of expected results/moves, and a monitor that compares as the DUT presents them.
module tb_maze_solver;
  import maze_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       run = 1'b0;
  logic       done, fail, move_valid;
  logic [1:0] move;
  logic [8:0] path_len;

  maze_solver_if mif ();

  maze_solver dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run        (run),
    .mem        (mif.master),
    .done       (done),
    .fail       (fail),
    .move       (move),
    .move_valid (move_valid),
    .path_len   (path_len)
  );

  always #5 clk = ~clk;

  logic maze [16][16];
  assign mif.mem_dout = maze[mif.x][mif.y];
  always @(posedge clk) if (mif.mem_wr) maze[mif.x][mif.y] <= mif.mem_din;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int both_total = 0;
  int mv_total = 0;

  typedef struct {
    logic       is_move;
    logic [1:0] mv;
    logic       is_done;
    logic [8:0] plen;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_result(input logic d, input int plen);
    sb.push_back('{is_move: 1'b0, mv: 2'd0, is_done: d, plen: 9'(plen)});
  endtask

  task automatic exp_moves(input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{is_move: 1'b1, mv: m, is_done: 1'b0, plen: 9'd0});
  endtask

  // Monitor: pops the scoreboard on every replayed move and on each new result.
  initial begin : monitor
    logic prev_res;
    exp_t e;
    prev_res = 1'b0;
    forever begin
      @(negedge clk);
      if (mif.mem_wr) wr_total++;
      if (mif.mem_wr && mif.mem_rd) both_total++;
      if (move_valid) begin
        mv_total++;
        if (sb.size() == 0 || !sb[0].is_move) begin
          checks++;
          errors++;
          $display("FAIL unexpected_move: got move=%0d, expected no move", move);
          if (sb.size() != 0) void'(sb.pop_front());
        end else begin
          e = sb.pop_front();
          check("replay_move", 32'(move), 32'(e.mv));
        end
      end
      if ((done || fail) && !prev_res) begin
        if (sb.size() == 0 || sb[0].is_move) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got done=%0d fail=%0d, expected none", done, fail);
          if (sb.size() != 0) void'(sb.pop_front());
        end else begin
          e = sb.pop_front();
          check("result_done", 32'(done), 32'(e.is_done));
          check("result_fail", 32'(fail), 32'(!e.is_done));
          check("result_path_len", 32'(path_len), 32'(e.plen));
        end
      end
      prev_res = done || fail;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill(input logic v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) maze[i][j] <= v;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string name, input int budget);
    int n;
    n = 0;
    while (!(done || fail) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no result after %0d cycles, expected done or fail", name, n);
    end
    @(negedge clk);
    check({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  // Counts cells whose contents differ from: all ones except row 15 columns 0..14.
  function automatic int serpentine_mismatches();
    int m;
    m = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (maze[i][j] !== ((i < 15) || (j == 15))) m++;
    return m;
  endfunction

  function automatic int zero_cells();
    int m;
    m = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (maze[i][j] !== 1'b1) m++;
    return m;
  endfunction

  initial begin : stimulus
    int w0, m0;

    // Reset state.
    rst = 1'b1;
    fill(1'b0);
    repeat (2) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_move_valid", 32'(move_valid), 32'd0);
    check("rst_move", 32'(move), 32'd0);
    check("rst_path_len", 32'(path_len), 32'd0);
    check("rst_mem_rd", 32'(mif.mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mif.mem_wr), 32'd0);
    check("rst_xy", {24'd0, mif.x, mif.y}, 32'd0);
    rst = 1'b0;

    // Blocked start cell: one read, no writes, immediate fail.
    fill(1'b0);
    maze[0][0] <= 1'b1;
    w0 = wr_total;
    exp_result(1'b0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_mem_rd", 32'(mif.mem_rd), 32'd1);
    check("t1_rd_xy", {24'd0, mif.x, mif.y}, 32'd0);
    @(negedge clk);
    check("t1_fail", 32'(fail), 32'd1);
    @(negedge clk);
    check("t1_no_writes", 32'(wr_total - w0), 32'd0);
    check("t1_sb_drained", 32'(sb.size()), 32'd0);

    // Open maze: serpentine path of 240 moves.
    fill(1'b0);
    exp_result(1'b1, 240);
    pulse_start();
    wait_result("t2", 5000);
    check("t2_maze_marks", 32'(serpentine_mismatches()), 32'd0);

    // Column 0 and row 15 open: 15 downs then 15 rights, then replay.
    fill(1'b1);
    for (int i = 0; i < 16; i++) begin
      maze[i][0]  <= 1'b0;
      maze[15][i] <= 1'b0;
    end
    exp_result(1'b1, 30);
    pulse_start();
    wait_result("t3", 2000);
    exp_moves(2'd3, 15);
    exp_moves(2'd1, 15);
    m0 = mv_total;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (40) @(negedge clk);
    check("t3_move_count", 32'(mv_total - m0), 32'd30);
    check("t3_sb_drained_replay", 32'(sb.size()), 32'd0);
    check("t3_done_after_replay", 32'(done), 32'd1);
    check("t3_path_len_hold", 32'(path_len), 32'd30);

    // Dead end of three cells: two pushes, full unwind, fail.
    fill(1'b1);
    maze[0][0] <= 1'b0;
    maze[0][1] <= 1'b0;
    maze[0][2] <= 1'b0;
    w0 = wr_total;
    exp_result(1'b0, 0);
    pulse_start();
    wait_result("t4", 500);
    check("t4_writes", 32'(wr_total - w0), 32'd3);
    check("t4_maze_all_ones", 32'(zero_cells()), 32'd0);

    // Goal walled off: exhaustive search, fail with empty stack.
    fill(1'b0);
    maze[15][15] <= 1'b1;
    exp_result(1'b0, 0);
    pulse_start();
    wait_result("t5", 8000);
    check("t5_stack_empty", 32'(dut.sp), 32'd0);
    check("t5_maze_all_ones", 32'(zero_cells()), 32'd0);

    // Reset mid-solve aborts asynchronously, then a fresh solve completes.
    fill(1'b0);
    pulse_start();
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_done", 32'(done), 32'd0);
    check("t6_async_fail", 32'(fail), 32'd0);
    check("t6_async_mem_wr", 32'(mif.mem_wr), 32'd0);
    check("t6_async_mem_rd", 32'(mif.mem_rd), 32'd0);
    check("t6_async_path_len", 32'(path_len), 32'd0);
    w0 = wr_total;
    repeat (3) @(negedge clk);
    check("t6_no_writes_in_reset", 32'(wr_total - w0), 32'd0);
    rst = 1'b0;
    fill(1'b0);
    exp_result(1'b1, 240);
    pulse_start();
    wait_result("t6", 5000);
    check("t6_maze_marks", 32'(serpentine_mismatches()), 32'd0);

    check("rd_wr_overlap", 32'(both_total), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
